// File: rtl/alu_operand_stage_if.sv
// Decode-to-ALU handshake bundle for alu_operand_stage.
// master = decode/ALU environment side, slave = the operand stage.
interface alu_operand_stage_if #(
    parameter int XLEN           = 32,
    parameter int MICROCODE_BITS = 9
);
    logic                      in_valid;
    logic                      in_ready;
    logic [MICROCODE_BITS-1:0] in_microcode;
    logic [XLEN-1:0]           in_rs1_data;
    logic [XLEN-1:0]           in_rs2_data;
    logic [XLEN-1:0]           in_imm;
    logic [XLEN-1:0]           in_pc;
    logic                      in_sel_a;
    logic                      in_sel_b;
    logic [4:0]                in_rs1_idx;
    logic [4:0]                in_rs2_idx;
    logic                      out_valid;
    logic                      out_ready;
    logic [MICROCODE_BITS-1:0] out_microcode;
    logic [XLEN-1:0]           out_a;
    logic [XLEN-1:0]           out_b;

    modport master (
        output in_valid, in_microcode, in_rs1_data, in_rs2_data, in_imm, in_pc,
        output in_sel_a, in_sel_b, in_rs1_idx, in_rs2_idx, out_ready,
        input  in_ready, out_valid, out_microcode, out_a, out_b
    );

    modport slave (
        input  in_valid, in_microcode, in_rs1_data, in_rs2_data, in_imm, in_pc,
        input  in_sel_a, in_sel_b, in_rs1_idx, in_rs2_idx, out_ready,
        output in_ready, out_valid, out_microcode, out_a, out_b
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand select with a registered 2-entry skid buffer (MAIN drives out_*, SKID absorbs back-pressure).
// Define ALU_OPERAND_FORWARD_EN to add write-back forwarding into captured and held operands.
//
// state   | meaning
// --------+----------------------------------------------
// S_EMPTY | no entry held, out_valid=0
// S_ONE   | MAIN holds the oldest entry, SKID free
// S_FULL  | MAIN oldest, SKID next, in_ready=0
module alu_operand_stage #(
    parameter int XLEN           = 32,
    parameter int MICROCODE_BITS = 9
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
`ifdef ALU_OPERAND_FORWARD_EN
    input  logic            wb_valid,
    input  logic [4:0]      wb_idx,
    input  logic [XLEN-1:0] wb_data,
`endif
    alu_operand_stage_if.slave bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [MICROCODE_BITS-1:0] mc;
        logic [XLEN-1:0]           a;
        logic [XLEN-1:0]           b;
`ifdef ALU_OPERAND_FORWARD_EN
        logic [4:0]                rs1_idx;
        logic [4:0]                rs2_idx;
        logic                      sel_a;
        logic                      sel_b;
`endif
    } entry_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t cap;
    entry_t main_held;
    entry_t skid_held;
    logic   accept;
    logic   consume;

`ifdef ALU_OPERAND_FORWARD_EN
    // Same rule serves capture-time bypass and in-place patching of held entries.
    function automatic entry_t fwd_patch(input entry_t e, input logic v,
                                         input logic [4:0] idx, input logic [XLEN-1:0] d);
        entry_t r;
        r = e;
        if (v && (idx != 5'd0)) begin
            if (!e.sel_a && (e.rs1_idx == idx)) r.a = d;
            if (!e.sel_b && (e.rs2_idx == idx)) r.b = d;
        end
        return r;
    endfunction
`else
    logic unused_fwd_idx;
    assign unused_fwd_idx = ^{bus.in_rs1_idx, bus.in_rs2_idx};
`endif

    assign bus.in_ready      = (state_q != S_FULL);
    assign bus.out_valid     = (state_q != S_EMPTY);
    assign bus.out_microcode = main_q.mc;
    assign bus.out_a         = main_q.a;
    assign bus.out_b         = main_q.b;

    assign accept  = bus.in_valid & bus.in_ready;
    assign consume = bus.out_valid & bus.out_ready;

    always_comb begin
        cap    = '0;
        cap.mc = bus.in_microcode;
        cap.a  = bus.in_sel_a ? bus.in_pc  : bus.in_rs1_data;
        cap.b  = bus.in_sel_b ? bus.in_imm : bus.in_rs2_data;
`ifdef ALU_OPERAND_FORWARD_EN
        cap.rs1_idx = bus.in_rs1_idx;
        cap.rs2_idx = bus.in_rs2_idx;
        cap.sel_a   = bus.in_sel_a;
        cap.sel_b   = bus.in_sel_b;
        cap         = fwd_patch(cap, wb_valid, wb_idx, wb_data);
        main_held   = fwd_patch(main_q, wb_valid, wb_idx, wb_data);
        skid_held   = fwd_patch(skid_q, wb_valid, wb_idx, wb_data);
`else
        main_held   = main_q;
        skid_held   = skid_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_held;
        skid_d  = skid_held;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d = S_ONE;
                    main_d  = cap;
                end
            end
            S_ONE: begin
                if (accept && !consume) begin
                    state_d = S_FULL;
                    skid_d  = cap;
                end else if (consume && !accept) begin
                    state_d = S_EMPTY;
                end else if (accept && consume) begin
                    main_d  = cap;
                end
            end
            S_FULL: begin
                if (consume) begin
                    state_d = S_ONE;
                    main_d  = skid_held;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Data registers may keep stale contents; only occupancy is cleared.
        if (flush) state_d = S_EMPTY;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: stimulus pushes hand-computed results on accept, a monitor pops on consume.
`timescale 1ns/1ps
module tb_alu_operand_stage;
    localparam int XLEN = 32;
    localparam int MCB  = 9;

    typedef struct packed {
        logic [MCB-1:0]  mc;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic flush   = 1'b0;
`ifdef ALU_OPERAND_FORWARD_EN
    logic            wb_valid = 1'b0;
    logic [4:0]      wb_idx   = 5'd0;
    logic [XLEN-1:0] wb_data  = '0;
`endif

    alu_operand_stage_if #(.XLEN(XLEN), .MICROCODE_BITS(MCB)) bus ();

    alu_operand_stage #(.XLEN(XLEN), .MICROCODE_BITS(MCB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
`ifdef ALU_OPERAND_FORWARD_EN
        .wb_valid(wb_valid),
        .wb_idx  (wb_idx),
        .wb_data (wb_data),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    exp_t exp_cur;
    exp_t prev_out;
    logic prev_hold;
    logic prev_wb;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pops   = 0;
    int   p0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [MCB-1:0] mc, input logic sa, input logic sb,
                        input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                        input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc,
                        input logic [4:0] i1, input logic [4:0] i2,
                        input logic [XLEN-1:0] ea, input logic [XLEN-1:0] eb);
        bus.in_valid     = 1'b1;
        bus.in_microcode = mc;
        bus.in_sel_a     = sa;
        bus.in_sel_b     = sb;
        bus.in_rs1_data  = rs1;
        bus.in_rs2_data  = rs2;
        bus.in_imm       = imm;
        bus.in_pc        = pc;
        bus.in_rs1_idx   = i1;
        bus.in_rs2_idx   = i2;
        exp_cur.mc       = mc;
        exp_cur.a        = ea;
        exp_cur.b        = eb;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // Monitor: checks ordering/values on consume and output stability while stalled.
    initial begin
        exp_t e;
        prev_hold = 1'b0;
        prev_wb   = 1'b0;
        prev_out  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                sb_q.delete();
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && bus.out_valid && !prev_wb)
                    chk("hold_stable", {bus.out_microcode, bus.out_a, bus.out_b}, prev_out);
                if (bus.out_valid && bus.out_ready) begin
                    n_pops++;
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_unexpected: got a=0x%0h b=0x%0h required no output",
                                 bus.out_a, bus.out_b);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_out", {bus.out_microcode, bus.out_a, bus.out_b}, e);
                    end
                end
                if (flush) sb_q.delete();
                else if (bus.in_valid && bus.in_ready) sb_q.push_back(exp_cur);
                prev_hold = bus.out_valid && !bus.out_ready;
                prev_out  = {bus.out_microcode, bus.out_a, bus.out_b};
`ifdef ALU_OPERAND_FORWARD_EN
                prev_wb   = wb_valid;
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_microcode = '0; bus.in_sel_a = 1'b0; bus.in_sel_b = 1'b0;
        bus.in_rs1_data = '0; bus.in_rs2_data = '0; bus.in_imm = '0; bus.in_pc = '0;
        bus.in_rs1_idx = '0; bus.in_rs2_idx = '0; bus.out_ready = 1'b1;
        exp_cur = '0;

        repeat (2) step();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_a", bus.out_a, 0);
        chk("rst_out_b", bus.out_b, 0);
        chk("rst_out_mc", bus.out_microcode, 0);
        reset_n = 1'b1;
        step();

        // 1: rs1 / imm select, one-cycle latency
        send(9'h000, 1'b0, 1'b1, 32'h10, 32'h55, 32'hFFFFFFFC, 32'h0, 5'd1, 5'd2, 32'h10, 32'hFFFFFFFC);
        step();
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_a", bus.out_a, 32'h10);
        chk("t1_b", bus.out_b, 32'hFFFFFFFC);
        idle();
        step();

        // 2: back-pressure fills both entries, then drain in order
        bus.out_ready = 1'b0;
        send(9'h011, 1'b0, 1'b0, 32'h1, 32'hB1, 32'h0, 32'h0, 5'd1, 5'd2, 32'h1, 32'hB1);
        step();
        send(9'h012, 1'b0, 1'b0, 32'h2, 32'hB2, 32'h0, 32'h0, 5'd1, 5'd2, 32'h2, 32'hB2);
        step();
        send(9'h013, 1'b0, 1'b0, 32'h3, 32'hB3, 32'h0, 32'h0, 5'd1, 5'd2, 32'h3, 32'hB3);
        chk("t2_full_in_ready", bus.in_ready, 0);
        chk("t2_full_a", bus.out_a, 32'h1);
        step();
        step();
        chk("t2_stall_in_ready", bus.in_ready, 0);
        chk("t2_stall_a", bus.out_a, 32'h1);
        p0 = n_pops;
        bus.out_ready = 1'b1;
        step();
        chk("t2_second_a", bus.out_a, 32'h2);
        step();
        idle();
        step();
        step();
        chk("t2_drain_count", n_pops - p0, 3);

        // 3: flush while FULL, then flush of a same-cycle accept while ONE
        bus.out_ready = 1'b0;
        send(9'h0A1, 1'b0, 1'b0, 32'hA1, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 32'hA1, 32'h0);
        step();
        send(9'h0A2, 1'b0, 1'b0, 32'hA2, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 32'hA2, 32'h0);
        step();
        send(9'h0A3, 1'b0, 1'b0, 32'hA3, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 32'hA3, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        chk("t3_flush_valid", bus.out_valid, 0);
        chk("t3_flush_ready", bus.in_ready, 1);
        send(9'h0B1, 1'b0, 1'b0, 32'hB1, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 32'hB1, 32'h0);
        step();
        send(9'h0B2, 1'b0, 1'b0, 32'hB2, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 32'hB2, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        chk("t3_flush_accept_valid", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        repeat (3) step();

        // 4: streaming PC / imm at one per cycle
        p0 = n_pops;
        for (int i = 0; i < 8; i++) begin
            send(MCB'(i), 1'b1, 1'b1, 32'hDEAD0000, 32'h0, 32'(i), 32'h100 + 32'(4 * i),
                 5'd3, 5'd4, 32'h100 + 32'(4 * i), 32'(i));
            chk("t4_in_ready", bus.in_ready, 1);
            step();
            chk("t4_stream_a", bus.out_a, 32'h100 + 32'(4 * i));
        end
        idle();
        step();
        chk("t4_throughput", n_pops - p0, 8);

        // 5: asynchronous reset while FULL
        bus.out_ready = 1'b0;
        send(9'h0C1, 1'b0, 1'b0, 32'hC1, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 32'hC1, 32'h0);
        step();
        send(9'h0C2, 1'b0, 1'b0, 32'hC2, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 32'hC2, 32'h0);
        step();
        idle();
        chk("t5_full", bus.in_ready, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_valid", bus.out_valid, 0);
        chk("t5_async_ready", bus.in_ready, 1);
        step();
        reset_n = 1'b1;
        chk("t5_post_valid", bus.out_valid, 0);
        chk("t5_post_a", bus.out_a, 0);
        bus.out_ready = 1'b1;
        send(9'h0D1, 1'b1, 1'b0, 32'h0, 32'h12345678, 32'h0, 32'h8000, 5'd1, 5'd2, 32'h8000, 32'h12345678);
        step();
        idle();
        step();
        step();

`ifdef ALU_OPERAND_FORWARD_EN
        // 6: write-back patches held MAIN; idx 0 never forwards; SKID->MAIN move gets patched
        bus.out_ready = 1'b0;
        send(9'h01F, 1'b0, 1'b0, 32'h11, 32'h22, 32'h0, 32'h0, 5'd5, 5'd6, 32'h11, 32'h22);
        step();
        idle();
        chk("t6_before_a", bus.out_a, 32'h11);
        wb_valid = 1'b1; wb_idx = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        wb_valid = 1'b0;
        chk("t6_patch_a", bus.out_a, 32'hDEADBEEF);
        chk("t6_patch_b", bus.out_b, 32'h22);
        flush = 1'b1;
        step();
        flush = 1'b0;
        send(9'h020, 1'b0, 1'b0, 32'h33, 32'h44, 32'h0, 32'h0, 5'd0, 5'd7, 32'h33, 32'h44);
        step();
        idle();
        wb_valid = 1'b1; wb_idx = 5'd0; wb_data = 32'h00000BAD;
        step();
        wb_valid = 1'b0;
        chk("t6_idx0_a", bus.out_a, 32'h33);
        flush = 1'b1;
        step();
        flush = 1'b0;
        send(9'h021, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 32'h0, 5'd7, 5'd9, 32'h44, 32'h0);
        step();
        send(9'h022, 1'b0, 1'b0, 32'h55, 32'h0, 32'h0, 32'h0, 5'd8, 5'd9, 32'h55, 32'h0);
        step();
        idle();
        wb_valid = 1'b1; wb_idx = 5'd8; wb_data = 32'h77;
        bus.out_ready = 1'b1;
        step();
        wb_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("t6_move_patch_a", bus.out_a, 32'h77);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.out_ready = 1'b1;
        step();
`endif

        idle();
        step();
        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Pipeline stage directly upstream of the ALU.
- Selects operand A (rs1 or PC) and operand B (rs2 or immediate) for each decoded instruction.
- Registers the selected operands together with the 9-bit ALU microcode.
- Presents them to the ALU through a 2-entry skid buffer with valid/ready handshakes on both sides, so decode back-pressure never creates a combinational ready path.

Parameters:
XLEN, 32, operand/data width.
MICROCODE_BITS, 9, width of the ALU microcode passed through.

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush (branch mispredict/trap)
in_valid  in  1  decode has an instruction
in_ready  out  1  stage can accept this cycle
in_microcode  in  MICROCODE_BITS  ALU microcode
in_rs1_data  in  XLEN  register-file rs1 value
in_rs2_data  in  XLEN  register-file rs2 value
in_imm  in  XLEN  sign-extended immediate
in_pc  in  XLEN  instruction PC
in_sel_a  in  1  0=rs1, 1=PC
in_sel_b  in  1  0=rs2, 1=imm
in_rs1_idx  in  5  rs1 index (forwarding only)
in_rs2_idx  in  5  rs2 index (forwarding only)
out_valid  out  1  operands valid to ALU
out_ready  in  1  ALU/next stage consumes
out_microcode  out  MICROCODE_BITS  registered microcode
out_a  out  XLEN  registered operand A
out_b  out  XLEN  registered operand B

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-low, on reset_n.
- Reset values: state=EMPTY, out_valid=0, out_a=0, out_b=0, out_microcode=0, skid register zeroed.
- Storage: two entries, MAIN and SKID. The out_* ports are driven directly from MAIN's registers, so the output path is registered with no combinational logic.
- in_ready = (state != FULL). It is a decode of state only and never depends on in_valid or out_ready.
- out_valid = (state != EMPTY).
- Definitions: accept = in_valid & in_ready; consume = out_valid & out_ready.
- States and transitions:
  - EMPTY:
    - accept → ONE; MAIN loads new entry.
  - ONE:
    - accept & !consume → FULL; SKID loads new entry.
    - consume & !accept → EMPTY.
    - accept & consume → ONE; MAIN loads new entry.
  - FULL (in_ready=0):
    - consume → ONE; MAIN loads SKID.
    - !consume → hold all.
- Operand select at capture: A = in_sel_a ? in_pc : in_rs1_data; B = in_sel_b ? in_imm : in_rs2_data. Values are passed bit-exact with no arithmetic in this stage.
- Latency: an accepted instruction appears on out_* the next cycle, when the stage was EMPTY or ONE-with-consume.
- Ordering: strict FIFO. No entry is ever dropped except by flush.
- flush has the highest priority:
  - Next state = EMPTY and out_valid=0 next cycle.
  - An accept in the same cycle is discarded.
  - A consume in the same cycle still completes from the consumer's view; data registers may hold stale values.
- Reset mid-operation: all entries are lost immediately and asynchronously; out_valid falls with reset_n.
- While out_valid=1 and out_ready=0, out_* must stay stable.

Optional Feature:
Macro: ALU_OPERAND_FORWARD_EN.
- Enabled, added inputs: wb_valid (1), wb_idx (5), wb_data (XLEN).
- Enabled, capture behaviour: if in_sel_a=0, wb_valid=1, wb_idx==in_rs1_idx and wb_idx!=0, then A captures wb_data instead of in_rs1_data. Operand B is handled the same way for rs2.
- Enabled, held entries: each MAIN/SKID entry stores its rs indices and sel bits. While an entry is held, every wb_valid write whose index matches a register-sourced, nonzero index patches that operand in place on the same edge.
- Enabled, SKID→MAIN move in the same cycle as a write: the moving entry receives the patch.
- Disabled: the wb_* ports and per-entry index storage are absent, and behaviour is exactly as in Behaviour.

Test Plan:
1. Reset, then in_valid=1, sel_a=0, sel_b=1, rs1=0x00000010, imm=0xFFFFFFFC, microcode=0x000, out_ready=1 → next cycle out_valid=1, out_a=0x10, out_b=0xFFFFFFFC, out_microcode=0x000.
2. out_ready=0, three back-to-back instructions with A=1,2,3 → after 2 accepts in_ready=0 and out_a stays 1. Then raise out_ready: outputs 1, 2, 3 in order with no loss or duplicate.
3. State FULL, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle instruction never appears.
4. Continuous in_valid/out_ready=1 for 8 instructions with sel_a=1, pc=0x100+4*i → one output per cycle with out_a=0x100+4*i, throughput 1/cycle.
5. Drop reset_n to 0 asynchronously mid-stream while FULL → out_valid=0 before the next clk edge; after release, state is EMPTY.
6. With ALU_OPERAND_FORWARD_EN defined: hold an entry rs1_idx=5 in MAIN with out_ready=0, then wb_valid=1, wb_idx=5, wb_data=0xDEADBEEF → out_a=0xDEADBEEF next cycle. Repeat with wb_idx=0 → operand unchanged.
